// File: rtl/keypad_pkg.sv
// keypad_pkg: scanner state type and 4x4 key code map.
// Shared by every keypad_scanner source file.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD
  } scan_state_t;

  localparam logic [3:0] KEYMAP [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

  function automatic logic [3:0] key_map(
    input logic [1:0] row_idx,
    input logic [1:0] col_idx
  );
    return KEYMAP[row_idx][col_idx];
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for asynchronous level inputs.
// Resets to RESET_VAL so idle pulled-up rows read as released.
module sync_2ff #(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix scan, debounce and two-digit key history.
// Define KEYPAD_AUTOREPEAT_EN to re-emit a held key every REPEAT_CYCLES.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_CYCLES     = 48000,
  parameter int DEBOUNCE_CYCLES = 2400000,
  parameter int REPEAT_CYCLES   = 24000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] digit_left,
  output logic [3:0] digit_right,
  output logic [3:0] key_code,
  output logic       key_valid
);

  localparam int MAX_SD =
    (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES : DEBOUNCE_CYCLES;
  localparam int MAX_P =
    (MAX_SD > REPEAT_CYCLES) ? MAX_SD : REPEAT_CYCLES;
  localparam int CW = $clog2(MAX_P + 1);

  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_CYCLES - 1);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
`ifdef KEYPAD_AUTOREPEAT_EN
  localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);
`endif

  scan_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0]    col_idx, col_n;
  logic [1:0]    row_idx, row_n;
  logic [3:0]    code_n, left_n, right_n;
  logic          kv_n;
  logic [3:0]    rows_s;
  logic          one_low;
  logic [1:0]    low_idx;
  logic          row_hi;
  logic [3:0]    hit_code;
`ifdef KEYPAD_AUTOREPEAT_EN
  logic [CW-1:0] rep, rep_n;
`endif

  sync_2ff #(
    .WIDTH     (4),
    .RESET_VAL (4'hF)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rows),
    .q     (rows_s)
  );

  assign cols     = ~(4'b0001 << col_idx);
  assign row_hi   = rows_s[row_idx];
  assign hit_code = key_map(row_idx, col_idx);

  // Any pattern other than a single low row counts as no key.
  always_comb begin
    one_low = 1'b1;
    low_idx = 2'd0;
    case (rows_s)
      4'b1110: low_idx = 2'd0;
      4'b1101: low_idx = 2'd1;
      4'b1011: low_idx = 2'd2;
      4'b0111: low_idx = 2'd3;
      default: one_low = 1'b0;
    endcase
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    col_n   = col_idx;
    row_n   = row_idx;
    kv_n    = 1'b0;
    code_n  = key_code;
    left_n  = digit_left;
    right_n = digit_right;
`ifdef KEYPAD_AUTOREPEAT_EN
    rep_n   = rep;
`endif
    unique case (state)
      SCAN: begin
        if (cnt == SCAN_LAST) begin
          cnt_n = '0;
          if (one_low) begin
            row_n   = low_idx;
            state_n = DEBOUNCE;
          end else begin
            col_n = col_idx + 2'd1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DEBOUNCE: begin
        if (row_hi) begin
          state_n = SCAN;
          cnt_n   = '0;
        end else if (cnt == DEB_LAST) begin
          kv_n    = 1'b1;
          code_n  = hit_code;
          left_n  = digit_right;
          right_n = hit_code;
          state_n = HELD;
          cnt_n   = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
          rep_n   = '0;
`endif
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      HELD: begin
        if (row_hi) begin
`ifdef KEYPAD_AUTOREPEAT_EN
          rep_n = '0;
`endif
          if (cnt == DEB_LAST) begin
            state_n = SCAN;
            cnt_n   = '0;
            col_n   = col_idx + 2'd1;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end else begin
          cnt_n = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
          if (rep == REP_LAST) begin
            kv_n    = 1'b1;
            code_n  = hit_code;
            left_n  = digit_right;
            right_n = hit_code;
            rep_n   = '0;
          end else begin
            rep_n = rep + 1'b1;
          end
`endif
        end
      end
      default: begin
        state_n = SCAN;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= SCAN;
      cnt         <= '0;
      col_idx     <= 2'd0;
      row_idx     <= 2'd0;
      key_valid   <= 1'b0;
      key_code    <= 4'h0;
      digit_left  <= 4'h0;
      digit_right <= 4'h0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep         <= '0;
`endif
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      col_idx     <= col_n;
      row_idx     <= row_n;
      key_valid   <= kv_n;
      key_code    <= code_n;
      digit_left  <= left_n;
      digit_right <= right_n;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep         <= rep_n;
`endif
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: matrix keypad model driving the scanner, with a
// queue of expected key entries checked whenever key_valid pulses.
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] rows;
  logic [3:0] cols;
  logic [3:0] digit_left;
  logic [3:0] digit_right;
  logic [3:0] key_code;
  logic       key_valid;

  keypad_scanner #(
    .SCAN_CYCLES     (4),
    .DEBOUNCE_CYCLES (16),
    .REPEAT_CYCLES   (64)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rows        (rows),
    .cols        (cols),
    .digit_left  (digit_left),
    .digit_right (digit_right),
    .key_code    (key_code),
    .key_valid   (key_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] code;
    logic [3:0] left;
    logic [3:0] right;
  } exp_t;

  localparam logic [3:0] KM [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

  exp_t       q[$];
  logic       pressed [4][4];
  logic [3:0] m_left;
  logic [3:0] m_right;
  int         checks   = 0;
  int         failures = 0;
  logic       prev_kv  = 1'b0;

  // A row reads low when a pressed key joins it to a driven-low column.
  always_comb begin
    rows = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r][c] && !cols[c]) rows[r] = 1'b0;
  end

  task automatic chk(input string name, input logic [3:0] act,
                     input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_key(input int r, input int c);
    exp_t e;
    m_left  = m_right;
    m_right = KM[r][c];
    e.code  = m_right;
    e.left  = m_left;
    e.right = m_right;
    q.push_back(e);
  endtask

  task automatic press(input int r, input int c, input int hold,
                       input int gap, input bit accepted);
    if (accepted) expect_key(r, c);
    pressed[r][c] = 1'b1;
    repeat (hold) @(negedge clk);
    pressed[r][c] = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic wait_col0();
    logic [3:0] prev;
    bit hit;
    hit  = 1'b0;
    prev = cols;
    for (int i = 0; i < 64 && !hit; i++) begin
      @(negedge clk);
      if (cols == 4'b1110 && prev != 4'b1110) hit = 1'b1;
      prev = cols;
    end
    checks++;
    if (!hit) begin
      failures++;
      $display("FAIL col0_sync: cols=%b never re-entered column 0", cols);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cols"}, cols, 4'b1110);
    chk({tag, "_valid"}, {3'b000, key_valid}, 4'h0);
    chk({tag, "_code"}, key_code, 4'h0);
    chk({tag, "_left"}, digit_left, 4'h0);
    chk({tag, "_right"}, digit_right, 4'h0);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      checks++;
      if ($countones(~cols) != 1) begin
        failures++;
        $display("FAIL cols_onehot: got %b expected one low bit", cols);
      end
      if (key_valid) begin
        checks++;
        if (prev_kv) begin
          failures++;
          $display("FAIL valid_back_to_back: got 1 expected 0");
        end
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_key: got code %h expected no pulse",
                   key_code);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (key_code !== e.code || digit_left !== e.left ||
              digit_right !== e.right) begin
            failures++;
            $display("FAIL key_entry: got code=%h l=%h r=%h expected code=%h l=%h r=%h",
                     key_code, digit_left, digit_right,
                     e.code, e.left, e.right);
          end
        end
      end
    end
    prev_kv = key_valid;
  end

  initial begin
    logic [3:0] e_cols;
    int r, c;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) pressed[i][j] = 1'b0;
    m_left  = 4'h0;
    m_right = 4'h0;
    reset   = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    reset = 1'b0;

    // Idle scan: column advances every 4 clocks and wraps.
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      e_cols = ~(4'b0001 << ((k / 4) % 4));
      chk("scan_cols", cols, e_cols);
    end

    // Key 5, then key 0 in the same column.
    press(1, 1, 40, 40, 1'b1);
    press(3, 1, 40, 40, 1'b1);

    // Bouncing key 1 resolves to a single entry.
    wait_col0();
    pressed[0][0] = 1'b1;
    repeat (6) @(negedge clk);
    pressed[0][0] = 1'b0;
    repeat (3) @(negedge clk);
    press(0, 0, 30, 40, 1'b1);

    // Two rows low in one column: ignored.
    pressed[0][0] = 1'b1;
    pressed[2][0] = 1'b1;
    repeat (40) @(negedge clk);
    pressed[0][0] = 1'b0;
    pressed[2][0] = 1'b0;
    repeat (40) @(negedge clk);

    // Held A masks a later press of 7 in another column.
    expect_key(0, 3);
    pressed[0][3] = 1'b1;
    repeat (45) @(negedge clk);
    pressed[2][0] = 1'b1;
    repeat (10) @(negedge clk);
    pressed[0][3] = 1'b0;
    pressed[2][0] = 1'b0;
    repeat (40) @(negedge clk);

    // Long hold of C.
    expect_key(2, 3);
`ifdef KEYPAD_AUTOREPEAT_EN
    expect_key(2, 3);
    expect_key(2, 3);
`endif
    press(2, 3, 200, 40, 1'b0);

    // Reset while debouncing key 1.
    wait_col0();
    pressed[0][0] = 1'b1;
    repeat (12) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk_reset_vals("mid_reset");
    pressed[0][0] = 1'b0;
    m_left  = 4'h0;
    m_right = 4'h0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);

    // Same key twice, then random keys.
    press(1, 1, 40, 40, 1'b1);
    press(1, 1, 40, 40, 1'b1);
    for (int n = 0; n < 10; n++) begin
      r = $urandom_range(0, 3);
      c = $urandom_range(0, 3);
      press(r, c, $urandom_range(45, 70), 40, 1'b1);
    end

    repeat (20) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL missing_keys: got %0d pending expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
